bcd_serial_adder: RTL and testbench

//  Digit-serial multi-digit BCD adder; the addition counterpart to the team's BCD subtractor.

---
 rtl/bcd_serial_adder.sv | 110 +++++++++++
 tb/tb_bcd_serial_adder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one decimal digit per clock, LSD first, with +6 decimal adjust.
// start/busy/done handshake; result registers hold until the next accepted start.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [3:0] a_dig;
    logic [3:0] b_dig;
    logic [4:0] t;
    logic [3:0] digit;
    logic       carry_next;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        a_dig      = a_reg[4*idx +: 4];
        b_dig      = b_reg[4*idx +: 4];
        t          = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
        digit      = t[3:0];
        carry_next = 1'b0;
        if (t > 5'd9) begin
            // Adding 6 modulo 16 is the decimal adjust; also defined for invalid nibbles.
            digit      = t[3:0] + 4'd6;
            carry_next = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        carry   <= 1'b0;
                        idx     <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                        invalid <= has_bad_digit(a) | has_bad_digit(b);
                        busy    <= 1'b1;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    sum[4*idx +: 4] <= digit;
                    carry           <= carry_next;
                    idx             <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout  <= carry_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): directed cases plus random operands
// compared against a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    int vectors     = 0;
    int miscompares = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int n = 0;
        for (int i = DIGITS - 1; i >= 0; i--) n = n * 10 + int'(v[4*i +: 4]);
        return n;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int n);
        logic [W-1:0] v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return v;
    endfunction

    function automatic logic any_bad(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Valid operands: plain decimal addition. Invalid nibbles: digit rule applied per nibble.
    task automatic ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                           output logic [W-1:0] rs, output logic rc, output logic rinv);
        int limit = 1;
        for (int i = 0; i < DIGITS; i++) limit *= 10;
        rinv = any_bad(ra) | any_bad(rb);
        if (!rinv) begin
            int n = bcd_to_int(ra) + bcd_to_int(rb);
            rc = (n >= limit);
            rs = int_to_bcd(n % limit);
        end else begin
            int c = 0;
            rs = '0;
            for (int i = 0; i < DIGITS; i++) begin
                int tt = int'(ra[4*i +: 4]) + int'(rb[4*i +: 4]) + c;
                if (tt > 9) begin
                    rs[4*i +: 4] = 4'((tt + 6) % 16);
                    c = 1;
                end else begin
                    rs[4*i +: 4] = 4'(tt);
                    c = 0;
                end
            end
            rc = c[0];
        end
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // One operation: accept at a posedge, scramble or re-request during ADD, check result and hold.
    task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input bit restart);
        logic [W-1:0] es;
        logic         ec;
        logic         ei;
        int           cyc;
        int           busy_cnt;
        bit           seen;
        ref_add(oa, ob, es, ec, ei);
        @(negedge clk);
        start = 1'b1;
        a     = oa;
        b     = ob;
        @(posedge clk);
        @(negedge clk);
        a     = $urandom();
        b     = $urandom();
        start = restart;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        busy_cnt = 1;
        seen     = 1'b0;
        cyc      = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            cyc = i;
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end else if (busy) begin
                busy_cnt++;
                if (restart) begin
                    a = $urandom();
                    b = $urandom();
                end
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(DIGITS));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(DIGITS));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_invalid"}, 32'(invalid), 32'(ei));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_sum_hold"}, 32'(sum), 32'(es));
        check({tag, "_cout_hold"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        int done_cnt;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_invalid", 32'(invalid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("t1", 16'h1234, 16'h4321, 1'b0);
        run_op("t2", 16'h9999, 16'h0001, 1'b0);
        run_op("t3a", 16'h0999, 16'h0001, 1'b0);
        run_op("t3b", 16'h5678, 16'h4567, 1'b0);
        run_op("t4", 16'h2468, 16'h1357, 1'b1);
        run_op("t6", 16'h00A0, 16'h0000, 1'b0);
        run_op("max_bad", 16'hFFFF, 16'hFFFF, 1'b0);

        // Reset during the second ADD cycle: abort to reset values with no done pulse.
        @(negedge clk);
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h4321;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t5_partial_sum", 32'(sum[3:0]), 32'd5);
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_sum", 32'(sum), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("t5_no_done", 32'(done_cnt), 32'd0);
        run_op("t5_after", 16'h0005, 16'h0005, 1'b0);

        for (int n = 0; n < 20; n++) run_op("rand", rand_bcd(), rand_bcd(), n[0]);
        for (int n = 0; n < 5; n++) run_op("rand_raw", W'($urandom()), W'($urandom()), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
